// File: rtl/twowire_apb_arbiter.sv
// Two-master, one-slave APB3 arbiter with round-robin grant, re-registered
// request fields toward the slave, and an optional hang watchdog.
//
// state  | meaning
// IDLE   | no transfer in flight; arbitration happens here
// SETUP  | dst_psel=1, dst_penable=0 for the granted request
// ACCESS | dst_psel=1, dst_penable=1, waiting on dst_pready or watchdog
module twowire_apb_arbiter #(
  parameter int unsigned ASIZE   = 0,
  parameter int unsigned TIMEOUT = 0,
  localparam int unsigned W_ADDR = 8 * (1 + ASIZE)
) (
  input  logic              dck,
  input  logic              drst_n,
  input  logic              m0_psel,
  input  logic              m0_penable,
  input  logic              m0_pwrite,
  input  logic [W_ADDR-1:0] m0_paddr,
  input  logic [31:0]       m0_pwdata,
  output logic              m0_pready,
  output logic              m0_pslverr,
  output logic [31:0]       m0_prdata,
  input  logic              m1_psel,
  input  logic              m1_penable,
  input  logic              m1_pwrite,
  input  logic [W_ADDR-1:0] m1_paddr,
  input  logic [31:0]       m1_pwdata,
  output logic              m1_pready,
  output logic              m1_pslverr,
  output logic [31:0]       m1_prdata,
  output logic              dst_psel,
  output logic              dst_penable,
  output logic              dst_pwrite,
  output logic [W_ADDR-1:0] dst_paddr,
  output logic [31:0]       dst_pwdata,
  input  logic              dst_pready,
  input  logic              dst_pslverr,
  input  logic [31:0]       dst_prdata,
  output logic              grant,
  output logic              busy,
  output logic              timeout_evt
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  // Watchdog fires on the TIMEOUT-th ACCESS cycle; timer counts from 0.
  localparam logic        WD_EN    = (TIMEOUT > 0);
  localparam logic [15:0] TMO_LAST = (TIMEOUT > 0) ? 16'(TIMEOUT - 1) : 16'd0;

  state_t      state;
  logic [15:0] timer;
  logic        in_access;
  logic        wd_fire;
  logic        xfer_done;
  logic        win;

  assign in_access = (state == ACCESS);
  // Slave response takes priority over a watchdog firing in the same cycle.
  assign wd_fire   = WD_EN && in_access && !dst_pready && (timer == TMO_LAST);
  assign xfer_done = in_access && (dst_pready || wd_fire);
  // Tie goes to the master that was not granted last; otherwise the sole requester.
  assign win       = (m0_psel && m1_psel) ? ~grant : ~m0_psel;

  assign busy = (state != IDLE);

  // Upstream response is routed only to the granted master and needs its penable.
  assign m0_pready  = xfer_done && (grant == 1'b0) && m0_penable;
  assign m0_pslverr = m0_pready && (dst_pslverr || wd_fire);
  assign m0_prdata  = m0_pready ? dst_prdata : 32'd0;
  assign m1_pready  = xfer_done && (grant == 1'b1) && m1_penable;
  assign m1_pslverr = m1_pready && (dst_pslverr || wd_fire);
  assign m1_prdata  = m1_pready ? dst_prdata : 32'd0;

  // Arbitration, downstream request registers, timer and watchdog pulse.
  always_ff @(posedge dck or negedge drst_n) begin
    if (!drst_n) begin
      state       <= IDLE;
      grant       <= 1'b1;
      dst_psel    <= 1'b0;
      dst_penable <= 1'b0;
      dst_pwrite  <= 1'b0;
      dst_paddr   <= '0;
      dst_pwdata  <= 32'd0;
      timer       <= 16'd0;
      timeout_evt <= 1'b0;
    end else begin
      timeout_evt <= wd_fire;
      case (state)
        IDLE: begin
          if (m0_psel || m1_psel) begin
            grant       <= win;
            dst_paddr   <= win ? m1_paddr  : m0_paddr;
            dst_pwrite  <= win ? m1_pwrite : m0_pwrite;
            dst_pwdata  <= win ? m1_pwdata : m0_pwdata;
            dst_psel    <= 1'b1;
            dst_penable <= 1'b0;
            state       <= SETUP;
          end
        end
        SETUP: begin
          dst_penable <= 1'b1;
          timer       <= 16'd0;
          state       <= ACCESS;
        end
        ACCESS: begin
          if (xfer_done) begin
            dst_psel    <= 1'b0;
            dst_penable <= 1'b0;
            timer       <= 16'd0;
            state       <= IDLE;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        default: begin
          dst_psel    <= 1'b0;
          dst_penable <= 1'b0;
          timer       <= 16'd0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule
